// File: rtl/xc_malu_pkg.sv
// rtl/xc_malu_pkg.sv - shared MALU types: sequencer state, packed-width encodings, finish counts.
package xc_malu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } malu_state_t;

    localparam logic [3:0] PW_16 = 4'b1000;
    localparam logic [3:0] PW_8  = 4'b0100;
    localparam logic [3:0] PW_4  = 4'b0010;
    localparam logic [3:0] PW_2  = 4'b0001;

    localparam int FINISH_16 = 32;
    localparam int FINISH_8  = 16;
    localparam int FINISH_4  = 8;
    localparam int FINISH_2  = 4;

    function automatic logic pw_is_valid(input logic [3:0] pw);
        return (pw != 4'b0000) && ((pw & (pw - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/xc_malu_pmul_seq.sv
// rtl/xc_malu_pmul_seq.sv - pmul/pmulh step sequencer driving the shared step datapath.
// Optional XC_MALU_PMUL_ZERO_SKIP_EN: zero operands complete without iterating.
module xc_malu_pmul_seq
    import xc_malu_pkg::*;
#(
    parameter int CW = 6
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          req_valid,
    input  logic          req_hi,
    input  logic [3:0]    req_pw,
    input  logic [31:0]   req_rs1,
    input  logic [31:0]   req_rs2,
    input  logic          flush,
    output logic          rsp_ready,
    output logic [31:0]   rsp_result,
    output logic          busy,
    output logic [31:0]   step_rs1,
    output logic [3:0]    step_pw,
    output logic [63:0]   step_acc,
    output logic [31:0]   step_arg_0,
    output logic [CW-1:0] step_count,
    input  logic [63:0]   step_n_acc,
    input  logic [31:0]   step_n_arg_0,
    input  logic [63:0]   step_result,
    input  logic          step_done
);

    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    malu_state_t   state_q, state_d;
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   arg_0_q, arg_0_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   rs1_q, rs1_d;
    logic [3:0]    pw_q, pw_d;
    logic          hi_q, hi_d;
    logic [31:0]   result_q, result_d;
    logic          zero_skip;

`ifdef XC_MALU_PMUL_ZERO_SKIP_EN
    assign zero_skip = (req_rs1 == 32'd0) || (req_rs2 == 32'd0);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        arg_0_d  = arg_0_q;
        count_d  = count_q;
        rs1_d    = rs1_q;
        pw_d     = pw_q;
        hi_d     = hi_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rs1_d   = req_rs1;
                    pw_d    = req_pw;
                    hi_d    = req_hi;
                    acc_d   = 64'd0;
                    arg_0_d = req_rs2;
                    count_d = '0;
                    if (!pw_is_valid(req_pw) || zero_skip) begin
                        state_d  = ST_DONE;
                        result_d = 32'd0;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (step_done) begin
                    result_d = hi_q ? step_result[63:32] : step_result[31:0];
                    state_d  = ST_DONE;
                end else if (count_q == COUNT_MAX) begin
                    // Datapath never reported finish: bail out rather than wrap.
                    result_d = 32'd0;
                    state_d  = ST_DONE;
                end else begin
                    acc_d   = step_n_acc;
                    arg_0_d = step_n_arg_0;
                    count_d = count_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = ST_IDLE;
            acc_d    = 64'd0;
            arg_0_d  = 32'd0;
            count_d  = '0;
            rs1_d    = rs1_q;
            pw_d     = pw_q;
            hi_d     = hi_q;
            result_d = result_q;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= 64'd0;
            arg_0_q  <= 32'd0;
            count_q  <= '0;
            rs1_q    <= 32'd0;
            pw_q     <= 4'd0;
            hi_q     <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            arg_0_q  <= arg_0_d;
            count_q  <= count_d;
            rs1_q    <= rs1_d;
            pw_q     <= pw_d;
            hi_q     <= hi_d;
            result_q <= result_d;
        end
    end

    assign rsp_ready  = (state_q == ST_DONE) && !flush;
    assign rsp_result = result_q;
    assign busy       = (state_q != ST_IDLE);
    assign step_rs1   = rs1_q;
    assign step_pw    = pw_q;
    assign step_acc   = acc_q;
    assign step_arg_0 = arg_0_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_xc_malu_pmul_seq.sv
// tb/tb_xc_malu_pmul_seq.sv - directed bench for xc_malu_pmul_seq with a behavioural step datapath.
module tb_xc_malu_pmul_seq;

    localparam int CW = 6;

    logic          g_clk = 1'b0;
    logic          g_reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_hi = 1'b0;
    logic [3:0]    req_pw = 4'd0;
    logic [31:0]   req_rs1 = 32'd0;
    logic [31:0]   req_rs2 = 32'd0;
    logic          flush = 1'b0;
    logic          rsp_ready;
    logic [31:0]   rsp_result;
    logic          busy;
    logic [31:0]   step_rs1;
    logic [3:0]    step_pw;
    logic [63:0]   step_acc;
    logic [31:0]   step_arg_0;
    logic [CW-1:0] step_count;
    logic [63:0]   step_n_acc;
    logic [31:0]   step_n_arg_0;
    logic [63:0]   step_result;
    logic          step_done;
    logic          hold_off_done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 g_clk = ~g_clk;

    xc_malu_pmul_seq #(.CW(CW)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .req_valid(req_valid), .req_hi(req_hi), .req_pw(req_pw),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .busy(busy),
        .step_rs1(step_rs1), .step_pw(step_pw), .step_acc(step_acc),
        .step_arg_0(step_arg_0), .step_count(step_count),
        .step_n_acc(step_n_acc), .step_n_arg_0(step_n_arg_0),
        .step_result(step_result), .step_done(step_done)
    );

    // Shift-add model: element e keeps a 2w-bit partial product in acc[e*2w +: 2w].
    function automatic int elem_w(input logic [3:0] pw);
        if (pw == 4'b1000) return 16;
        if (pw == 4'b0100) return 8;
        if (pw == 4'b0010) return 4;
        if (pw == 4'b0001) return 2;
        return 0;
    endfunction

    function automatic logic [63:0] model_n_acc(input logic [63:0] acc, input logic [31:0] rs1,
                                                 input logic [31:0] arg, input logic [3:0] pw,
                                                 input int cnt);
        logic [63:0] na, f, a, m2, m1;
        int w;
        w  = elem_w(pw);
        na = acc;
        if (w != 0 && cnt < w) begin
            m2 = (64'd1 << (2 * w)) - 64'd1;
            m1 = (64'd1 << w) - 64'd1;
            for (int e = 0; e < 32 / w; e++) begin
                if (arg[e * w]) begin
                    f  = (na >> (e * 2 * w)) & m2;
                    a  = ({32'd0, rs1} >> (e * w)) & m1;
                    f  = (f + (a << cnt)) & m2;
                    na = (na & ~(m2 << (e * 2 * w))) | (f << (e * 2 * w));
                end
            end
        end
        return na;
    endfunction

    function automatic logic [63:0] model_result(input logic [63:0] acc, input logic [3:0] pw);
        logic [63:0] f, m2, m1;
        logic [31:0] lo, hi;
        int w;
        w  = elem_w(pw);
        lo = 32'd0;
        hi = 32'd0;
        if (w != 0) begin
            m2 = (64'd1 << (2 * w)) - 64'd1;
            m1 = (64'd1 << w) - 64'd1;
            for (int e = 0; e < 32 / w; e++) begin
                f  = (acc >> (e * 2 * w)) & m2;
                lo = lo | 32'((f & m1) << (e * w));
                hi = hi | 32'(((f >> w) & m1) << (e * w));
            end
        end
        return {hi, lo};
    endfunction

    always_comb begin
        step_n_acc   = model_n_acc(step_acc, step_rs1, step_arg_0, step_pw, int'(step_count));
        step_n_arg_0 = step_arg_0 >> 1;
        step_result  = model_result(step_acc, step_pw);
        step_done    = !hold_off_done && (elem_w(step_pw) != 0) &&
                       (int'(step_count) == 2 * elem_w(step_pw));
    end

    // Latency = negedges after the accept edge until rsp_ready is seen.
    task automatic run_op(input logic hi, input logic [3:0] pw, input logic [31:0] a,
                          input logic [31:0] b, input int budget, output int lat, output logic got);
        @(negedge g_clk);
        req_valid = 1'b1; req_hi = hi; req_pw = pw; req_rs1 = a; req_rs2 = b;
        @(posedge g_clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < budget) begin
            @(negedge g_clk);
            req_valid = 1'b0;
            req_rs1 = 32'hDEAD_BEEF; req_rs2 = 32'hCAFE_F00D;
            lat++;
            got = rsp_ready;
        end
    endtask

    task automatic test_reset;
        g_reset = 1'b1;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        n_checks++;
        if ({rsp_ready, busy, rsp_result, step_acc, step_arg_0, step_count, step_rs1, step_pw} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b busy=%b res=%h acc=%h arg=%h cnt=%0d rs1=%h pw=%b, required all zero",
                     rsp_ready, busy, rsp_result, step_acc, step_arg_0, step_count, step_rs1, step_pw);
        end
        g_reset = 1'b0;
    endtask

    task automatic test_pmul16;
        int lat; logic got;
        run_op(1'b0, 4'b1000, 32'h0003_0002, 32'h0005_0007, 100, lat, got);
        n_checks++;
        if (!got || lat !== 34) begin
            n_fail++; $display("FAIL pmul16_latency: got=%b lat=%0d, required 34", got, lat);
        end
        n_checks++;
        if (rsp_result !== 32'h000F_000E) begin
            n_fail++; $display("FAIL pmul16_result: %h, required 000f000e", rsp_result);
        end
        @(negedge g_clk);
        n_checks++;
        if (rsp_ready !== 1'b0 || busy !== 1'b0 || rsp_result !== 32'h000F_000E) begin
            n_fail++;
            $display("FAIL pmul16_pulse: rdy=%b busy=%b res=%h, required 0 0 000f000e", rsp_ready, busy, rsp_result);
        end
    endtask

    task automatic test_pmulh16;
        int lat; logic got;
        run_op(1'b1, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 100, lat, got);
        n_checks++;
        if (!got || rsp_result !== 32'hFFFE_FFFE) begin
            n_fail++; $display("FAIL pmulh16_result: got=%b res=%h, required fffefffe", got, rsp_result);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic got;
        run_op(1'b0, 4'b0100, 32'h0403_0201, 32'h0101_0101, 100, lat, got);
        n_checks++;
        if (!got || lat !== 18 || rsp_result !== 32'h0403_0201) begin
            n_fail++; $display("FAIL b2b_first: got=%b lat=%0d res=%h, required 18 04030201", got, lat, rsp_result);
        end
        // Hold the request through DONE: it must only be taken in the following IDLE cycle.
        req_valid = 1'b1; req_hi = 1'b0; req_pw = 4'b0100;
        req_rs1 = 32'h0403_0201; req_rs2 = 32'h0101_0101;
        @(negedge g_clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_not_in_done: busy=%b, required 0", busy);
        end
        @(posedge g_clk);
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge g_clk);
            req_valid = 1'b0;
            lat++;
            got = rsp_ready;
        end
        n_checks++;
        if (!got || lat !== 18 || rsp_result !== 32'h0403_0201) begin
            n_fail++; $display("FAIL b2b_second: got=%b lat=%0d res=%h, required 18 04030201", got, lat, rsp_result);
        end
    endtask

    task automatic test_flush;
        int lat, seen; logic got;
        @(negedge g_clk);
        req_valid = 1'b1; req_hi = 1'b0; req_pw = 4'b0001; req_rs1 = 32'h5555_5555; req_rs2 = 32'hFFFF_FFFF;
        @(negedge g_clk);
        req_valid = 1'b0;
        @(negedge g_clk);
        @(negedge g_clk);
        flush = 1'b1;
        n_checks++;
        if (rsp_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL flush_cycle: rdy=%b busy=%b, required 0 1", rsp_ready, busy);
        end
        @(negedge g_clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || step_count !== '0 || step_acc !== 64'd0 || rsp_result !== 32'h0403_0201) begin
            n_fail++;
            $display("FAIL flush_after: busy=%b cnt=%0d acc=%h res=%h, required 0 0 0 04030201",
                     busy, step_count, step_acc, rsp_result);
        end
        seen = 0;
        repeat (12) begin
            @(negedge g_clk);
            if (rsp_ready) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL flush_no_rsp: %0d responses, required 0", seen);
        end
        run_op(1'b0, 4'b0010, 32'h0000_0003, 32'h0000_0003, 100, lat, got);
        n_checks++;
        if (!got || lat !== 10 || rsp_result !== 32'h0000_0009) begin
            n_fail++; $display("FAIL flush_next_op: got=%b lat=%0d res=%h, required 10 00000009", got, lat, rsp_result);
        end
    endtask

    task automatic test_reset_mid_run;
        int seen;
        @(negedge g_clk);
        req_valid = 1'b1; req_hi = 1'b0; req_pw = 4'b1000; req_rs1 = 32'h1234_5678; req_rs2 = 32'h0F0F_0F0F;
        @(negedge g_clk);
        req_valid = 1'b0;
        repeat (5) @(negedge g_clk);
        g_reset = 1'b1;
        @(negedge g_clk);
        n_checks++;
        if ({rsp_ready, busy, rsp_result, step_acc, step_arg_0, step_count, step_rs1, step_pw} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: rdy=%b busy=%b res=%h acc=%h arg=%h cnt=%0d rs1=%h pw=%b, required all zero",
                     rsp_ready, busy, rsp_result, step_acc, step_arg_0, step_count, step_rs1, step_pw);
        end
        g_reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge g_clk);
            if (rsp_ready || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL reset_mid_run_quiet: %0d active cycles, required 0", seen);
        end
    endtask

    task automatic test_invalid_pw;
        int lat; logic got;
        logic [3:0] pws [2];
        pws[0] = 4'b0000;
        pws[1] = 4'b0011;
        run_op(1'b0, 4'b0010, 32'h0000_0007, 32'h0000_0002, 100, lat, got);
        for (int i = 0; i < 2; i++) begin
            run_op(1'b0, pws[i], 32'h0000_0007, 32'h0000_0002, 100, lat, got);
            n_checks++;
            if (!got || lat !== 1 || rsp_result !== 32'd0) begin
                n_fail++;
                $display("FAIL invalid_pw_%b: got=%b lat=%0d res=%h, required 1 00000000", pws[i], got, lat, rsp_result);
            end
        end
    endtask

    task automatic test_saturate;
        int lat; logic got;
        run_op(1'b0, 4'b0010, 32'h0000_0003, 32'h0000_0003, 100, lat, got);
        hold_off_done = 1'b1;
        run_op(1'b0, 4'b0100, 32'h0403_0201, 32'h0101_0101, 200, lat, got);
        hold_off_done = 1'b0;
        n_checks++;
        if (!got || lat !== 65 || rsp_result !== 32'd0) begin
            n_fail++; $display("FAIL saturate: got=%b lat=%0d res=%h, required 65 00000000", got, lat, rsp_result);
        end
    endtask

    task automatic test_zero_skip;
        int lat, exp_lat; logic got;
`ifdef XC_MALU_PMUL_ZERO_SKIP_EN
        exp_lat = 1;
`else
        exp_lat = 18;
`endif
        run_op(1'b0, 4'b0010, 32'h0000_0003, 32'h0000_0003, 100, lat, got);
        run_op(1'b0, 4'b0100, 32'h0403_0201, 32'h0000_0000, 100, lat, got);
        n_checks++;
        if (!got || lat !== exp_lat || rsp_result !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_operand: got=%b lat=%0d res=%h, required %0d 00000000", got, lat, rsp_result, exp_lat);
        end
    endtask

    initial begin
        test_reset;
        test_pmul16;
        test_pmulh16;
        test_back_to_back;
        test_flush;
        test_reset_mid_run;
        test_invalid_pw;
        test_saturate;
        test_zero_skip;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
